park_ctrl_multi: RTL

Parametrised multi-slot car-park controller: admits vehicles through a password-checked entry gate, assigns each the lowest free slot, and releases slots on exit by vehicle number. It is the next generation of the single-lane park gate controller in the access-control subsystem. It adds configurable capacity, an exit path, occupancy tracking, duplicate/unknown-vehicle errors and optional wrong-password lockout.

---
 rtl/park_pkg.sv | 33 +++
 rtl/park_slot_table.sv | 72 +++++++
 rtl/park_ctrl_multi.sv | 231 +++++++++++++++++++++++
 3 files changed

// File: rtl/park_pkg.sv
// park_pkg: shared definitions for the multi-slot car-park controller.
//   - park_state_e : controller state encoding
//   - CLOSE / OPEN : gate output levels
//   - lowest_free(): index of the lowest cleared valid bit, or n when all
//     of the first n slots are occupied
package park_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_CHECK = 3'd1,
    ST_ENTER = 3'd2,
    ST_EXIT  = 3'd3,
    ST_LOCK  = 3'd4
  } park_state_e;

  localparam logic CLOSE = 1'b0;
  localparam logic OPEN  = 1'b1;

  // Upper bound on capacity; the search function works on a vector this wide.
  localparam int MAX_SLOTS = 256;

  // Scans downwards so the last assignment made is the lowest free index.
  function automatic int lowest_free(input logic [MAX_SLOTS-1:0] valid,
                                     input int n);
    int idx;
    idx = n;
    for (int i = MAX_SLOTS - 1; i >= 0; i--) begin
      if (i < n && !valid[i]) idx = i;
    end
    return idx;
  endfunction

endpackage

// File: rtl/park_slot_table.sv
// park_slot_table: SLOTS x ID_W vehicle-number store with per-slot valid bits.
// Ports:
//   clk, rst            : clock, synchronous active-high reset (valid bits only)
//   key                 : vehicle number to look up
//   hit, hit_idx        : key found in an occupied slot, and that slot's index
//   has_free, free_idx  : at least one slot free, and the lowest free index
//   wr_en, wr_idx, wr_id: store wr_id into wr_idx and mark it occupied
//   clr_en, clr_idx     : mark clr_idx free
module park_slot_table
  import park_pkg::*;
#(
  parameter int ID_W  = 4,
  parameter int SLOTS = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [ID_W-1:0]          key,
  output logic                     hit,
  output logic [$clog2(SLOTS)-1:0] hit_idx,
  output logic                     has_free,
  output logic [$clog2(SLOTS)-1:0] free_idx,
  input  logic                     wr_en,
  input  logic [$clog2(SLOTS)-1:0] wr_idx,
  input  logic [ID_W-1:0]          wr_id,
  input  logic                     clr_en,
  input  logic [$clog2(SLOTS)-1:0] clr_idx
);

  localparam int SW = $clog2(SLOTS);

  logic [ID_W-1:0]      ids [SLOTS];
  logic [SLOTS-1:0]     valid;
  logic [MAX_SLOTS-1:0] valid_ext;
  int                   free_pos;

  always_comb begin
    valid_ext             = '0;
    valid_ext[SLOTS-1:0]  = valid;
    free_pos              = lowest_free(valid_ext, SLOTS);
    has_free              = (free_pos < SLOTS);
    free_idx              = free_pos[SW-1:0];
  end

  // Descending scan leaves the lowest matching index; at most one slot
  // can match because duplicates are refused on entry.
  always_comb begin
    hit     = 1'b0;
    hit_idx = '0;
    for (int i = SLOTS - 1; i >= 0; i--) begin
      if (valid[i] && ids[i] == key) begin
        hit     = 1'b1;
        hit_idx = i[SW-1:0];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      valid <= '0;
    end else begin
      if (wr_en)  valid[wr_idx]  <= 1'b1;
      if (clr_en) valid[clr_idx] <= 1'b0;
    end
  end

  // Stored numbers are meaningless while their valid bit is clear,
  // so they carry no reset.
  always_ff @(posedge clk) begin
    if (wr_en) ids[wr_idx] <= wr_id;
  end

endmodule

// File: rtl/park_ctrl_multi.sv
// park_ctrl_multi: multi-slot car-park controller. Admits vehicles through a
// password-checked entry gate into the lowest free slot and releases slots
// on exit by vehicle number.
// Ports:
//   clk, rst   : clock, synchronous active-high reset
//   start      : entry request (level, held while at the gate)
//   exit_req   : exit request pulse, qualified by vn
//   pswd, vn   : presented password, vehicle number
//   front      : entry gate open during password stage
//   back       : admission granted (held GATE_CYC cycles)
//   exit_gate  : exit gate open (held GATE_CYC cycles)
//   slot       : slot index granted or released
//   count      : occupied slots; full / empty flags registered with it
//   err        : one-cycle error pulse
//   locked     : wrong-password lockout active
// Build option: define PARK_LOCKOUT_EN to enable the try counter and LOCK
// state; otherwise retries are unlimited and locked is tied low.
module park_ctrl_multi
  import park_pkg::*;
#(
  parameter int               ID_W      = 4,
  parameter int               SLOTS     = 16,
  parameter int               PSWD_W    = 4,
  parameter logic [PSWD_W-1:0] PASSWORD = 4'b1010,
  parameter int               GATE_CYC  = 2,
  parameter int               MAX_TRIES = 3,
  parameter int               LOCK_CYC  = 8
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       start,
  input  logic                       exit_req,
  input  logic [PSWD_W-1:0]          pswd,
  input  logic [ID_W-1:0]            vn,
  output logic                       front,
  output logic                       back,
  output logic                       exit_gate,
  output logic [$clog2(SLOTS)-1:0]   slot,
  output logic [$clog2(SLOTS+1)-1:0] count,
  output logic                       full,
  output logic                       empty,
  output logic                       err,
  output logic                       locked
);

  localparam int SW = $clog2(SLOTS);
  localparam int CW = $clog2(SLOTS + 1);
  localparam int GW = $clog2(GATE_CYC + 1);

  localparam logic [CW-1:0] FULL_CNT  = CW'(SLOTS);
  localparam logic [CW-1:0] ONE_CNT   = CW'(1);
  localparam logic [GW-1:0] GATE_LAST = GW'(GATE_CYC - 1);

  localparam logic [2:0] IDLE  = ST_IDLE;
  localparam logic [2:0] CHECK = ST_CHECK;
  localparam logic [2:0] ENTER = ST_ENTER;
  localparam logic [2:0] EXIT  = ST_EXIT;

  if (SLOTS < 2 || SLOTS > MAX_SLOTS || GATE_CYC < 1 ||
      MAX_TRIES < 1 || LOCK_CYC < 1) begin : g_bad_cfg
    $error("park_ctrl_multi: unsupported parameter set");
  end

  logic [2:0]      state;
  logic [GW-1:0]   gate_cnt;
  logic [ID_W-1:0] id_lat;

  logic          hit, has_free;
  logic [SW-1:0] hit_idx, free_idx;
  logic          pswd_ok, do_admit, do_exit;

`ifdef PARK_LOCKOUT_EN
  localparam int            TW        = $clog2(MAX_TRIES + 1);
  localparam int            LW        = $clog2(LOCK_CYC + 1);
  localparam logic [TW-1:0] TRY_LAST  = TW'(MAX_TRIES - 1);
  localparam logic [LW-1:0] LOCK_LAST = LW'(LOCK_CYC - 1);
  localparam logic [2:0]    LOCK      = ST_LOCK;

  logic [TW-1:0] tries;
  logic [LW-1:0] lock_cnt;
`else
  assign locked = 1'b0;
`endif

  assign pswd_ok  = (pswd == PASSWORD);
  // Abort (start low) wins over a matching password.
  assign do_admit = (state == CHECK) && start && pswd_ok;
  // Exit has priority over entry in IDLE.
  assign do_exit  = (state == IDLE) && exit_req && hit;

  park_slot_table #(
    .ID_W  (ID_W),
    .SLOTS (SLOTS)
  ) u_table (
    .clk      (clk),
    .rst      (rst),
    .key      (vn),
    .hit      (hit),
    .hit_idx  (hit_idx),
    .has_free (has_free),
    .free_idx (free_idx),
    .wr_en    (do_admit),
    .wr_idx   (free_idx),
    .wr_id    (id_lat),
    .clr_en   (do_exit),
    .clr_idx  (hit_idx)
  );

  // Vehicle number captured when the entry request is accepted; the table
  // write in CHECK uses this copy, not the live vn.
  always_ff @(posedge clk) begin
    if (state == IDLE && start && !exit_req) id_lat <= vn;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      front     <= CLOSE;
      back      <= CLOSE;
      exit_gate <= CLOSE;
      err       <= 1'b0;
      slot      <= '0;
      count     <= '0;
      full      <= 1'b0;
      empty     <= 1'b1;
      gate_cnt  <= '0;
`ifdef PARK_LOCKOUT_EN
      tries     <= '0;
      lock_cnt  <= '0;
      locked    <= 1'b0;
`endif
    end else begin
      err <= 1'b0;
      case (state)
        IDLE: begin
          if (exit_req) begin
            if (hit) begin
              exit_gate <= OPEN;
              slot      <= hit_idx;
              count     <= count - ONE_CNT;
              full      <= 1'b0;
              empty     <= (count == ONE_CNT);
              gate_cnt  <= GATE_LAST;
              state     <= EXIT;
            end else begin
              err <= 1'b1;
            end
          end else if (start) begin
            if (full || hit) begin
              err <= 1'b1;
            end else begin
              front <= OPEN;
              state <= CHECK;
            end
          end
        end

        CHECK: begin
          if (!start) begin
            front <= CLOSE;
            state <= IDLE;
`ifdef PARK_LOCKOUT_EN
            tries <= '0;
`endif
          end else if (pswd_ok) begin
            back     <= OPEN;
            slot     <= free_idx;
            count    <= count + ONE_CNT;
            full     <= (count == FULL_CNT - ONE_CNT);
            empty    <= 1'b0;
            gate_cnt <= GATE_LAST;
            state    <= ENTER;
`ifdef PARK_LOCKOUT_EN
            tries    <= '0;
`endif
          end else begin
            err <= 1'b1;
`ifdef PARK_LOCKOUT_EN
            if (tries == TRY_LAST) begin
              front    <= CLOSE;
              locked   <= 1'b1;
              lock_cnt <= LOCK_LAST;
              tries    <= '0;
              state    <= LOCK;
            end else begin
              tries <= tries + 1'b1;
            end
`endif
          end
        end

        ENTER, EXIT: begin
          if (gate_cnt == '0) begin
            front     <= CLOSE;
            back      <= CLOSE;
            exit_gate <= CLOSE;
            state     <= IDLE;
          end else begin
            gate_cnt <= gate_cnt - 1'b1;
          end
        end

`ifdef PARK_LOCKOUT_EN
        LOCK: begin
          if (lock_cnt == '0) begin
            locked <= 1'b0;
            state  <= IDLE;
          end else begin
            lock_cnt <= lock_cnt - 1'b1;
          end
        end
`endif

        default: begin
          front     <= CLOSE;
          back      <= CLOSE;
          exit_gate <= CLOSE;
          state     <= IDLE;
        end
      endcase
    end
  end

  // The FSM refuses entry when full and only exits a found vehicle, so the
  // occupancy count can neither wrap up nor down.
  a_no_overflow: assert property (@(posedge clk) disable iff (rst)
    do_admit |-> (count != FULL_CNT) && has_free);
  a_no_underflow: assert property (@(posedge clk) disable iff (rst)
    do_exit |-> (count != '0));

endmodule
